// File: rtl/led_bar_pkg.sv
// led_bar_pkg: shared sizes and prescaler helper for the LED bargraph driver
package led_bar_pkg;
  localparam int N_LEDS = 8;
  localparam int BAR_W = 4;
  function automatic int MS_DIV(input int clk_freq_hz);
    return clk_freq_hz / 1000;
  endfunction
endpackage

// File: rtl/ms_tick_gen.sv
// ms_tick_gen: free-running prescaler emitting a 1-cycle tick every DIV cycles
module ms_tick_gen #(
  parameter int DIV = 50000
) (
  input  logic clk,
  input  logic reset_n,
  output logic tick_o
);
  localparam int CW = (DIV > 1) ? $clog2(DIV) : 1;
  logic [CW-1:0] cnt_q, cnt_d;
  always_comb begin
    tick_o = cnt_q == CW'(DIV - 1);
    cnt_d = tick_o ? '0 : cnt_q + 1'b1;
  end
  always_ff @(posedge clk or negedge reset_n)
    if (!reset_n) cnt_q <= '0;
    else cnt_q <= cnt_d;
endmodule

// File: rtl/led_bargraph_driver.sv
// led_bargraph_driver: PIO level byte to PWM-dimmed thermometer bar with decaying peak marker
module led_bargraph_driver
  import led_bar_pkg::*;
#(
  parameter int CLK_FREQ_HZ = 50000000,
  parameter int HOLD_MS = 500,
  parameter int DECAY_MS = 60
) (
  input  logic              clk,
  input  logic              reset_n,
  input  logic [N_LEDS-1:0] level_in,
  input  logic [7:0]        brightness,
  input  logic              raw_mode,
  input  logic              peak_en,
  output logic [N_LEDS-1:0] leds
);
  localparam int HW = $clog2(HOLD_MS + 1);
  localparam int DW = (DECAY_MS > 1) ? $clog2(DECAY_MS) : 1;
  logic [N_LEDS-1:0] level_q, leds_q, leds_d, bar_mask, peak_mask;
  logic [BAR_W-1:0]  bar_q, bar_d, peak_q, peak_d;
  logic [HW-1:0]     hold_q, hold_d;
  logic [DW-1:0]     decay_q, decay_d;
  logic [7:0]        pwm_q;
  logic              tick, pwm_on;
  ms_tick_gen #(.DIV(MS_DIV(CLK_FREQ_HZ))) u_tick (
    .clk(clk),
    .reset_n(reset_n),
    .tick_o(tick)
  );
  always_comb begin
    bar_d = BAR_W'((9'(level_q) + 9'd31) >> 5);
    peak_d = peak_q;
    hold_d = hold_q;
    decay_d = decay_q;
    // a new high (or equal) level always wins over a same-cycle tick
    if (bar_q >= peak_q) begin
      peak_d = bar_q;
      hold_d = HW'(HOLD_MS);
      decay_d = DW'(DECAY_MS - 1);
    end else if (tick && hold_q != '0) begin
      hold_d = hold_q - 1'b1;
    end else if (tick) begin
      decay_d = (decay_q == '0) ? DW'(DECAY_MS - 1) : decay_q - 1'b1;
      peak_d = (decay_q == '0) ? peak_q - 1'b1 : peak_q;
    end
    pwm_on = (brightness == 8'hFF) | (pwm_q < brightness);
    bar_mask = N_LEDS'((9'd1 << bar_q) - 9'd1);
    peak_mask = (peak_q != '0) ? N_LEDS'(9'd1 << (peak_q - 1'b1)) : '0;
    leds_d = raw_mode ? level_q : ({N_LEDS{pwm_on}} & bar_mask) | ({N_LEDS{peak_en}} & peak_mask);
  end
  always_ff @(posedge clk or negedge reset_n)
    if (!reset_n) begin
      level_q <= '0;
      bar_q <= '0;
      peak_q <= '0;
      hold_q <= '0;
      decay_q <= '0;
      pwm_q <= '0;
      leds_q <= '0;
    end else begin
      level_q <= level_in;
      bar_q <= bar_d;
      peak_q <= peak_d;
      hold_q <= hold_d;
      decay_q <= decay_d;
      pwm_q <= pwm_q + 1'b1;
      leds_q <= leds_d;
    end
  assign leds = leds_q;
endmodule

// File: tb/tb_led_bargraph_driver.sv
// tb_led_bargraph_driver: random and directed stimulus checked every cycle against a tick-counting peak model
module tb_led_bargraph_driver;
  localparam int CF = 10000, HM = 3, DM = 2, DIV = CF / 1000;
  logic clk = 0, reset_n = 1, raw_mode = 0, peak_en = 0;
  logic [7:0] level_in = 0, brightness = 0, leds;
  int vectors = 0, errors = 0;
  always #5 clk = ~clk;
  led_bargraph_driver #(.CLK_FREQ_HZ(CF), .HOLD_MS(HM), .DECAY_MS(DM)) dut (
    .clk(clk), .reset_n(reset_n), .level_in(level_in), .brightness(brightness),
    .raw_mode(raw_mode), .peak_en(peak_en), .leds(leds)
  );
  // model: cycles since reset give tick and PWM phase; peak drops once per DM ticks after HM ticks without a new high
  int n_m, ts_m, peak_m, bar_m;
  logic [7:0] lq_m, leds_m;
  function automatic logic [7:0] bar_view(int bar, int peak, logic on, logic pe);
    logic [7:0] v;
    v = 0;
    for (int i = 0; i < 8; i++) v[i] = (on && i < bar) || (pe && peak > 0 && i == peak - 1);
    return v;
  endfunction
  always @(posedge clk or negedge reset_n)
    if (!reset_n) begin
      n_m <= 0; ts_m <= 0; peak_m <= 0; bar_m <= 0; lq_m <= 0; leds_m <= 0;
    end else begin
      n_m <= n_m + 1;
      lq_m <= level_in;
      bar_m <= (lq_m + 31) / 32;
      leds_m <= raw_mode ? lq_m :
        bar_view(bar_m, peak_m, brightness == 255 || (n_m % 256) < brightness, peak_en);
      if (bar_m >= peak_m) begin
        peak_m <= bar_m; ts_m <= 0;
      end else if (n_m % DIV == DIV - 1) begin
        ts_m <= ts_m + 1;
        if (ts_m + 1 > HM && (ts_m + 1 - HM) % DM == 0) peak_m <= peak_m - 1;
      end
    end
  always @(negedge clk) begin
    vectors++;
    if (leds !== leds_m) begin
      errors++;
      $display("FAIL model t=%0t leds=%h expected=%h", $time, leds, leds_m);
    end
  end
  task automatic cyc(input int k);
    repeat (k) @(negedge clk);
  endtask
  task automatic check(input string nm, input logic [7:0] exp);
    vectors++;
    if (leds !== exp) begin
      errors++;
      $display("FAIL %s leds=%h expected=%h", nm, leds, exp);
    end
  endtask
  task automatic check_int(input string nm, input int act, input int lo, input int hi);
    vectors++;
    if (act < lo || act > hi) begin
      errors++;
      $display("FAIL %s got=%0d expected=%0d..%0d", nm, act, lo, hi);
    end
  endtask
  task automatic wait_for(input logic [7:0] exp, input int bound, output int waited);
    waited = 0;
    while (leds !== exp && waited < bound) begin
      cyc(1);
      waited++;
    end
    check("wait_leds", exp);
  endtask
  logic [7:0] lv [6] = '{8'd0, 8'd1, 8'd32, 8'd33, 8'd200, 8'd255};
  logic [7:0] bx [6] = '{8'h00, 8'h01, 8'h01, 8'h03, 8'h7F, 8'hFF};
  initial begin
    int cnt, bad, w;
    logic [7:0] e;
    level_in = 8'hFF; brightness = 8'd255;
    #1 reset_n = 0;
    cyc(3);
    check("reset_hold", 8'h00);
    reset_n = 1;
    cyc(3);
    check("reset_release", 8'hFF);
    for (int i = 0; i < 6; i++) begin
      level_in = lv[i];
      cyc(3);
      check("bar_map", bx[i]);
    end
    level_in = 8'hFF; brightness = 8'd64;
    cyc(3);
    cnt = 0; bad = 0;
    repeat (256) begin
      cyc(1);
      if (leds == 8'hFF) cnt++;
      else if (leds != 8'h00) bad++;
    end
    check_int("pwm_64_on", cnt, 64, 64);
    check_int("pwm_uniform", bad, 0, 0);
    brightness = 8'd0;
    cyc(3);
    bad = 0;
    repeat (40) begin
      cyc(1);
      if (leds != 8'h00) bad++;
    end
    check_int("pwm_zero", bad, 0, 0);
    peak_en = 1;
    cyc(4);
    check("peak_capture", 8'h80);
    level_in = 8'h00;
    wait_for(8'h40, 100, w);
    check_int("hold_then_first_step", w, 44, 53);
    for (int k = 6; k >= 0; k--) begin
      e = (k > 0) ? 8'(1 << (k - 1)) : 8'h00;
      wait_for(e, 40, w);
      check_int("decay_step_interval", w, 20, 20);
    end
    level_in = 8'hFF;
    cyc(4);
    level_in = 8'h00;
    wait_for(8'h10, 200, w);
    while (n_m % DIV != 7) cyc(1);
    level_in = 8'hE0;
    cyc(4);
    check("recapture", 8'h40);
    level_in = 8'h00;
    cyc(30);
    check("hold_restart", 8'h40);
    level_in = 8'hE0;
    cyc(4);
    raw_mode = 1; brightness = 8'($urandom); level_in = 8'hA5;
    cyc(2);
    check("raw_mirror", 8'hA5);
    raw_mode = 0; brightness = 8'd0; level_in = 8'h00;
    cyc(1);
    check("raw_exit_peak", 8'h40);
    repeat (300) begin
      level_in = 8'($urandom);
      case ($urandom % 3)
        0: brightness = 8'd0;
        1: brightness = 8'd255;
        default: brightness = 8'($urandom);
      endcase
      raw_mode = ($urandom % 8) == 0;
      peak_en = 1'($urandom);
      if ($urandom % 40 == 0) begin
        #2 reset_n = 0;
        cyc(1);
        reset_n = 1;
      end
      cyc($urandom_range(1, 30));
      if ($urandom % 4 == 0) begin
        level_in = 8'd0;
        cyc($urandom_range(20, 120));
      end
    end
    $display("== %0d vectors applied, %0d miscompares ==", vectors, errors);
    $finish;
  end
endmodule

// File: doc/led_bargraph_driver.md
Name: led_bargraph_driver

Overview:
- Downstream consumer of the 8-bit LED PIO output in the theremin Nios system.
- Converts the CPU-written level byte into an 8-LED thermometer bar, dimmed by PWM.
- Adds a peak-hold marker that decays over time, so pitch and volume activity stays visible on the board LEDs.
- Provides a raw bypass mode that mirrors the PIO byte directly onto the LEDs (legacy behaviour).

Parameters:
- CLK_FREQ_HZ, 50000000, system clock frequency; sets the 1 ms tick prescaler (CLK_FREQ_HZ/1000 cycles per tick).
- HOLD_MS, 500, time in ticks the peak marker holds before decay starts.
- DECAY_MS, 60, ticks per one-LED step of peak decay.

Ports:
- clk  in  1  system clock
- reset_n  in  1  asynchronous active-low reset
- level_in  in  8  level byte from LED PIO out_port
- brightness  in  8  PWM duty for bar LEDs; 0 = off, 255 = always on
- raw_mode  in  1  1 = leds mirror level_in; 0 = bargraph mode
- peak_en  in  1  1 = show peak marker
- leds  out  8  LED drive, active high, registered

Behaviour:
- Clock and reset: one clock, clk. Reset is asynchronous, active-low, on reset_n.
- Reset values: leds=0, level_q=0, bar_cnt=0, peak=0, hold_cnt=0, decay_cnt=0, pwm_cnt=0, prescaler=0.
- Input register: level_q <= level_in every cycle. level_in is same-domain; no synchroniser.
- Bar count:
  - bar_cnt = (level_q + 31) >> 5, computed in 9-bit arithmetic, range 0..8.
  - Mapping: 0→0, 1..32→1, 33..64→2, ..., 225..255→8.
  - bar_cnt is registered.
- Tick: 1-cycle pulse every CLK_FREQ_HZ/1000 cycles. The prescaler runs continuously from reset.
- Peak tracking (evaluated every cycle):
  - If bar_cnt >= peak: peak <= bar_cnt and hold_cnt <= HOLD_MS. This reload takes priority over any tick in the same cycle.
  - Else, if tick and hold_cnt != 0: hold_cnt decrements.
  - Else, if tick and hold_cnt == 0: decay_cnt decrements. When decay_cnt reaches 0, decay_cnt <= DECAY_MS-1 and peak <= peak-1. peak never goes below bar_cnt.
  - decay_cnt is reloaded to DECAY_MS-1 whenever hold_cnt is reloaded.
- PWM:
  - pwm_cnt is a free-running 8-bit counter that wraps 255→0.
  - pwm_on = (brightness == 255) | (pwm_cnt < brightness).
- Output (registered):
  - raw_mode=1: leds <= level_q. PWM and peak are ignored; peak tracking keeps running.
  - raw_mode=0: leds[i] <= (pwm_on & (i < bar_cnt)) | (peak_en & (peak != 0) & (i == peak-1)).
  - The peak LED is unmodulated, i.e. full brightness.
- Latency:
  - level_in → leds: 3 cycles in bargraph mode (level_q, bar_cnt, leds).
  - level_in → leds: 2 cycles in raw mode.
- Boundaries:
  - level 255 → all 8 LEDs lit.
  - brightness 0 → only the peak LED can be lit.
  - peak == bar_cnt → the peak LED coincides with the top bar LED; the OR keeps it lit at full brightness.
  - A mode change takes effect on the next output register update; no state is cleared.
  - Reset asserted mid-hold or mid-decay clears all state immediately.

Decomposition:
- Shared package led_bar_pkg:
  - N_LEDS = 8
  - BAR_W = 4 (width of bar_cnt and peak)
  - MS_DIV function, returning CLK_FREQ_HZ/1000
- One sub-module, ms_tick_gen: a parameterised prescaler producing the 1-cycle tick.
- All other logic stays in led_bargraph_driver.

Test Plan (simulation parameters: CLK_FREQ_HZ=10000, so tick every 10 cycles; HOLD_MS=3; DECAY_MS=2):
- Reset: hold reset_n=0 with level_in=0xFF → leds=0x00. Release reset → leds=0xFF by cycle 3 (brightness=255, raw_mode=0).
- Bar mapping: brightness=255, peak_en=0, level_in = 0, 1, 32, 33, 200, 255 → leds = 0x00, 0x01, 0x01, 0x03, 0x7F, 0xFF.
- PWM: level_in=0xFF, brightness=64, peak_en=0 → each LED high for exactly 64 of every 256 cycles. brightness=0 → leds=0 permanently.
- Peak hold/decay: level_in=0xFF then 0x00, peak_en=1, brightness=0:
  - leds=0x80 held for 3 ticks.
  - Then steps 0x40, 0x20, ... with one step every 2 ticks.
  - Reaches 0x00 after 8 steps.
- Peak re-capture: during decay (leds=0x10), apply level_in=0xE0 → peak reloads to 7, leds=0x40 (brightness=0), hold restarts. A simultaneous tick does not decrement.
- Raw mode: raw_mode=1, level_in=0xA5 → leds=0xA5 two cycles later, regardless of brightness or peak. Return to raw_mode=0 → bargraph resumes with the retained peak.
